// File: rtl/alu_share_arb.sv
// Round-robin front end sharing one combinational ALU between two requesters.
// Operands are held for a per-op cycle count, then the result is returned on a valid/ready port.
module alu_share_arb #(
    parameter int unsigned LONG_CYCLES  = 4,
    parameter int unsigned SHORT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_y,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_y,
    output logic        rsp_zero,
    output logic        busy
);
    localparam logic [3:0] ALU_MUL = 4'd10;
    localparam logic [3:0] ALU_DIV = 4'd11;
    localparam logic [3:0] ALU_MOD = 4'd12;

    localparam logic [3:0] LONG_LOAD  = 4'(LONG_CYCLES - 1);
    localparam logic [3:0] SHORT_LOAD = 4'(SHORT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    logic        prio;
    logic [3:0]  cnt;
    logic        grant0;
    logic        grant1;
    logic [3:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

    function automatic logic is_long(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

    // prio only breaks ties; a lone valid is always granted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = !prio;
            grant1 = prio;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;

    assign sel_op = grant1 ? req1_op : req0_op;
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_y     <= '0;
            rsp_zero  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        alu_op <= sel_op;
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        rsp_id <= grant1;
                        prio   <= grant0;
                        cnt    <= is_long(sel_op) ? LONG_LOAD : SHORT_LOAD;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_y     <= alu_y;
                        rsp_zero  <= alu_zero;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: acts as the ALU and checks every cycle against a
// transaction-level timeline model (accept edge, capture edge, handshake).
module tb_alu_share_arb;
    localparam int LONG_N  = 4;
    localparam int SHORT_N = 1;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10, OP_DIV = 4'd11;
    localparam logic [3:0] OP_MOD = 4'd12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_op;
    logic        alu_zero;
    logic        rsp_valid, rsp_id, rsp_zero, busy;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_y;

    int errors = 0;
    int checks = 0;

    alu_share_arb #(.LONG_CYCLES(LONG_N), .SHORT_CYCLES(SHORT_N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'd0, a < b};
            OP_MUL:  return a * b;
            OP_DIV:  begin
                if (b == 32'd0) return 32'd0;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $unsigned($signed(a) / $signed(b));
            end
            OP_MOD:  begin
                if (b == 32'd0) return 32'd0;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $unsigned($signed(a) % $signed(b));
            end
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_y    = alu_fn(alu_op, alu_a, alu_b);
        alu_zero = (alu_y == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Timeline model: a transaction is in flight from its accept edge until the
    // handshake edge; its result is visible from accept_edge + N onward.
    int          cyc = 0;
    bit          have = 1'b0;
    int          cap_cyc = 0;
    bit          m_prio = 1'b0;
    logic [31:0] e_a = '0, e_b = '0, pend_y = '0, old_y = '0;
    logic [3:0]  e_op = '0;
    logic        e_id = 1'b0, pend_z = 1'b0, old_z = 1'b0;

    task automatic tick();
        bit g0, g1, resp;
        int n;
        #1;
        if (req0_valid && req1_valid) begin
            g0 = (m_prio == 1'b0);
            g1 = (m_prio == 1'b1);
        end else begin
            g0 = req0_valid;
            g1 = req1_valid;
        end
        resp = have && (cyc >= cap_cyc);
        check("req0_ready", req0_ready, !have && g0);
        check("req1_ready", req1_ready, !have && g1);
        check("busy", busy, have);
        check("rsp_valid", rsp_valid, resp);
        check("rsp_id", rsp_id, e_id);
        check("rsp_y", rsp_y, resp ? pend_y : old_y);
        check("rsp_zero", rsp_zero, resp ? pend_z : old_z);
        check("alu_a", alu_a, e_a);
        check("alu_b", alu_b, e_b);
        check("alu_op", alu_op, e_op);

        if (rst) begin
            have = 1'b0; m_prio = 1'b0;
            e_a = '0; e_b = '0; e_op = '0; e_id = 1'b0;
            old_y = '0; old_z = 1'b0;
        end else if (!have && (g0 || g1)) begin
            e_id   = g1;
            e_op   = g1 ? req1_op : req0_op;
            e_a    = g1 ? req1_a : req0_a;
            e_b    = g1 ? req1_b : req0_b;
            pend_y = alu_fn(e_op, e_a, e_b);
            pend_z = (pend_y == 32'd0);
            n      = (e_op == OP_MUL || e_op == OP_DIV || e_op == OP_MOD) ? LONG_N : SHORT_N;
            cap_cyc = cyc + 1 + n;
            m_prio = !g1;
            have   = 1'b1;
        end else if (resp && rsp_ready) begin
            have  = 1'b0;
            old_y = pend_y;
            old_z = pend_z;
        end

        @(posedge clk);
        cyc++;
        #2;
    endtask

    task automatic set_req0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic set_req1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    initial begin
        logic [31:0] held_y;
        int          seen;
        bit          got_valid;
        bit          exp_id;

        rst = 1'b1;
        @(posedge clk);
        #2;
        tick();
        rst = 1'b0;

        // Single short request.
        rsp_ready = 1'b1;
        set_req0(1'b1, OP_ADD, 32'd5, 32'd7);
        tick();
        set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
        check("add_alu_a", alu_a, 32'd5);
        tick();
        check("add_valid", rsp_valid, 1'b1);
        check("add_y", rsp_y, 32'd12);
        check("add_zero", rsp_zero, 1'b0);
        check("add_id", rsp_id, 1'b0);
        tick();

        // Long op from requester 1.
        set_req1(1'b1, OP_MUL, 32'hFFFF_FFFD, 32'd6);
        tick();
        set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mul_hold_a", alu_a, 32'hFFFF_FFFD);
            check("mul_early_valid", rsp_valid, 1'b0);
        end
        tick();
        check("mul_valid", rsp_valid, 1'b1);
        check("mul_y", rsp_y, 32'hFFFF_FFEE);
        check("mul_id", rsp_id, 1'b1);
        tick();

        // Continuous contention alternates grants.
        set_req0(1'b1, OP_SUB, 32'd9, 32'd9);
        set_req1(1'b1, OP_DIV, 32'd10, 32'd0);
        seen = 0;
        exp_id = 1'b0;
        for (int i = 0; i < 60 && seen < 4; i++) begin
            tick();
            if (rsp_valid) begin
                check("cont_id", rsp_id, exp_id);
                check("cont_zero", rsp_zero, 1'b1);
                check("cont_y", rsp_y, 32'd0);
                exp_id = !exp_id;
                seen++;
            end
        end
        check("cont_count", seen, 4);

        // Backpressure.
        set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
        while (busy) tick();
        rsp_ready = 1'b0;
        set_req0(1'b1, OP_ADD, 32'd1, 32'd2);
        got_valid = 1'b0;
        for (int i = 0; i < 20 && !got_valid; i++) begin
            tick();
            got_valid = rsp_valid;
        end
        check("bp_reach_valid", got_valid, 1'b1);
        set_req1(1'b1, OP_XOR, 32'd3, 32'd3);
        held_y = rsp_y;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_y", rsp_y, held_y);
            check("bp_busy", busy, 1'b1);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_idle", busy, 1'b0);
        tick();
        check("bp_next_accept", busy, 1'b1);
        set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
        set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
        for (int i = 0; i < 10 && busy; i++) tick();

        // Reset in the middle of a DIV.
        set_req0(1'b1, OP_DIV, 32'd100, 32'd7);
        tick();
        set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_alu_op", alu_op, 32'd0);
        check("rst_rsp_y", rsp_y, 32'd0);
        for (int i = 0; i < 6; i++) tick();

        // Withdrawn request from requester 1 while a response is pending.
        rsp_ready = 1'b0;
        set_req0(1'b1, OP_OR, 32'h0F, 32'hF0);
        tick();
        set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
        for (int i = 0; i < 10 && !rsp_valid; i++) tick();
        set_req1(1'b1, OP_ADD, 32'd1, 32'd1);
        tick();
        set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            set_req0($urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
            set_req1($urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
            rsp_ready = ($urandom_range(0, 99) < 65);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Sequencing front end that shares the single combinational `alu` between two requesters (e.g. the integer issue slot and the address/branch unit). It arbitrates round-robin and registers operands into the ALU. It holds the operands stable for a per-op number of cycles, so MUL/DIV/MOD can be constrained as multicycle paths. It then returns the registered result through a valid/ready response port tagged with the requester id.

## Interface
- `LONG_CYCLES`, default 4: cycles the ALU is held for `ALU_MUL`/`ALU_DIV`/`ALU_MOD`; legal range 2..15.
- `SHORT_CYCLES`, default 1: cycles held for every other op; legal range 1..15.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_op`, `req1_op`  in  4  ALU op code (`ALU_*` from decode.vh).
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32  operands.
- `alu_a`, `alu_b`  out  32  registered operands driven to the ALU.
- `alu_op`  out  4  registered op driven to the ALU.
- `alu_y`  in  32  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  1  requester that issued the result.
- `rsp_y`  out  32  registered result.
- `rsp_zero`  out  1  registered zero flag.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from the valids and the priority pointer `prio`.
  - If only one valid is high, grant it.
  - If both are high, grant `prio`.
  - `reqN_ready` = (state==IDLE) && grantN. At most one ready is high; neither is high outside IDLE.
- On accept (valid&&ready):
  - Latch op/a/b into `alu_op`/`alu_a`/`alu_b` and the id into `rsp_id`.
  - Load the counter with LONG_CYCLES-1 if op is MUL/DIV/MOD, else SHORT_CYCLES-1.
  - Set `prio` to the non-granted requester.
  - Go to EXEC.
- EXEC:
  - If counter==0, capture `alu_y`/`alu_zero` into `rsp_y`/`rsp_zero` and go to RESP.
  - Otherwise decrement the counter.
  - `alu_*` outputs are constant throughout EXEC.
- RESP:
  - `rsp_valid`=1; `rsp_y`/`rsp_zero`/`rsp_id` are stable until the handshake.
  - On `rsp_ready`, go to IDLE.
  - No new request is accepted in the handshake cycle.
- `alu_*` and `rsp_*` data registers hold their last values in IDLE and never toggle without an accept or capture.
- Unknown op codes pass through with SHORT_CYCLES. The ALU returns 0, zero=1.
- Div/mod by zero gets no special handling; the ALU flag semantics pass through unchanged.

## Timing
- Reset values:
  - State=IDLE, `prio`=0, counter=0.
  - `alu_a`=`alu_b`=0, `alu_op`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_y`=0, `rsp_zero`=0, `busy`=0.
  - `reqN_ready` follow the combinational rule above: a valid present in the first cycle after reset is granted.
- Latency, for an accept at edge T (N = cycles for the op):
  - `alu_*` valid after T.
  - Capture at edge T+N.
  - `rsp_valid` high from T+N until `rsp_ready` is sampled high.
  - Minimum accept-to-accept interval is N+2 cycles (accept, N EXEC, RESP with immediate ready, then IDLE).
- `rsp_valid` is registered; `reqN_ready` depends only on state, `prio` and valids. There is no combinational path from `rsp_ready` to `reqN_ready`.
- Simultaneous valids: alternate strictly under continuous contention, so each requester is served every other transaction.
- Requester valid deasserting before acceptance is legal. The request is dropped with no state change.
- `rst` in EXEC or RESP returns to IDLE next edge. The in-flight result is discarded, with no `rsp_valid` pulse.

## Test plan
- Reset then single request: `req0` ADD a=5, b=7 → `req0_ready` same cycle; `rsp_valid` 1 cycle later (SHORT_CYCLES=1) with `rsp_y`=12, `rsp_zero`=0, `rsp_id`=0.
- Long op: `req1` MUL a=-3, b=6 → `alu_a`/`alu_b` stable for 4 cycles; `rsp_y`=0xFFFFFFEE, `rsp_id`=1, captured exactly 4 edges after accept.
- Contention: both valid continuously with SUB 9-9 (req0) and DIV 10/0 (req1) → grants 0,1,0,1; req0 gives `rsp_y`=0, `rsp_zero`=1; req1 gives `rsp_zero`=1; `rsp_id` alternates.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` → `rsp_*` constant, both readies 0, `busy`=1; first ready → IDLE, next request accepted one cycle later.
- Reset mid-EXEC of DIV → next cycle `busy`=0, `rsp_valid`=0, all data outputs 0, `prio`=0, and the stale result never appears.
- Valid withdrawn: `req1_valid` pulses while state is RESP, then drops → never granted, no response with `rsp_id`=1.
